load_store_unit: RTL
====================

Name: load_store_unit

Overview:
- Sits between the EX/MEM pipeline register and the word-addressed data memory (`data_mem`).
- Converts RV32I loads and stores (LB/LH/LW/LBU/LHU, SB/SH/SW) into word accesses. Sub-word stores use read-modify-write (RMW); sub-word loads are sign- or zero-extended.
- Flags misaligned, out-of-range and illegal-funct3 requests.
- Valid/ready request side; single-cycle response pulse.

Parameters:
- MEM_WORDS, 512, number of 32-bit words in data memory; word index >= MEM_WORDS is out of range.
- ADDR_WIDTH, 32, byte address width.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit idle; request accepted on posedge when req_valid&req_ready.
- req_write  in  1  1=store, 0=load.
- req_funct3  in  3  RV32I funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU).
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  32  store data (rs2).
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load result; 0 for stores and faults.
- resp_fault  out  1  request aborted, no memory side effect.
- resp_cause  out  2  01 misaligned, 10 out of range, 11 illegal funct3, 00 none.
- mem_read  out  1  to memReadDM.
- mem_write  out  1  to memWriteDM; memory writes on the negedge inside this cycle.
- mem_addr  out  32  to addressDM; word-aligned, low 2 bits always 0.
- mem_wdata  out  32  to writeDataDM.
- mem_rdata  in  32  from readDataDM; combinational, valid in the same cycle as mem_read.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE; req_ready=1; resp_valid=0; resp_rdata=0; resp_fault=0; resp_cause=00; mem_read=0; mem_write=0; mem_addr=0; mem_wdata=0.
- Reset mid-operation aborts immediately. A negedge write already performed stays in memory. No response is issued.
- States: IDLE, RD, WR, RESP.
- mem_* outputs are decoded from registered state and latched request fields only, never from req_*.
- IDLE: req_ready=1. On accept, latch funct3/addr/wdata/write, then check in priority order:
  - illegal funct3 (011, 110, 111; or 100/101 with write=1) -> RESP, cause 11.
  - misaligned (H: addr[0]!=0; W: addr[1:0]!=0) -> RESP, cause 01.
  - addr[31:2] >= MEM_WORDS -> RESP, cause 10.
  - otherwise: load or sub-word store -> RD; SW -> WR.
- RD: mem_read=1, mem_addr={addr[31:2],2'b00}. At posedge:
  - load: extract lane, extend into resp_rdata, go to RESP.
  - store: capture mem_rdata as old word, go to WR.
- WR: mem_write=1, mem_addr as in RD.
  - SW: mem_wdata = wdata.
  - SB: old word with byte lane addr[1:0] replaced by wdata[7:0].
  - SH: old word with half-lane addr[1] replaced by wdata[15:0].
  - Next state: RESP.
- RESP: resp_valid=1 for exactly one cycle. resp_* hold their values until the next response. Next state: IDLE.
- Little-endian lanes: byte k = bits [8k+7:8k].
  - LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend.
- Latency, accept edge to resp_valid high:
  - faults: 1 cycle.
  - loads and SW: 2 cycles.
  - SB/SH: 3 cycles.
- req_ready=0 in RD, WR and RESP. Back-to-back throughput: one request per (latency+1) cycles.
- Faulting requests never assert mem_read or mem_write.

Optional Feature:
- Macro LSU_MISALIGN_TRAP_EN.
- Defined: misaligned requests fault with cause 01, as above.
- Undefined: misalignment is never flagged.
  - H accesses use addr[1] only (addr[0] ignored).
  - W accesses ignore addr[1:0].
  - The access proceeds normally; cause 01 is never produced.

Test Plan:
- Reset during WR of an SB -> mem_write drops asynchronously; after release req_ready=1, resp_valid=0, all outputs 0.
- SW addr=0x8, wdata=0xDEADBEEF; then LW addr=0x8 -> resp_rdata=0xDEADBEEF, LW resp_valid 2 cycles after accept.
- Word 0x10 = 0x11223344; SB addr=0x11, wdata=0xAA -> word = 0x1122AA44, 3-cycle latency, exactly one mem_write cycle. Then LB addr=0x11 -> 0xFFFFFFAA; LBU addr=0x11 -> 0x000000AA.
- SH addr=0x12, wdata=0x8001 -> word 0x10 = 0x8001AA44. LH addr=0x12 -> 0xFFFF8001; LHU -> 0x00008001.
- Out of range and illegal funct3, checking that mem_read and mem_write stay 0 throughout:
  - LW addr=4*MEM_WORDS (0x800) -> resp_fault=1, cause 10, 1-cycle latency.
  - funct3=011 -> cause 11.
- LH addr=0x13:
  - with LSU_MISALIGN_TRAP_EN -> fault, cause 01.
  - without it -> reads half addr[1]=1 of word 0x10, resp_rdata=0xFFFF8001, no fault.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I load/store to word-addressed data memory with RMW sub-word stores.
// Optional macro LSU_MISALIGN_TRAP_EN enables misalignment faults (cause 01).
`default_nettype none

module load_store_unit #(
  parameter int MEM_WORDS  = 512,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_fault,
  output logic [1:0]            resp_cause,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [31:0]           mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RD   = 2'd1;
  localparam logic [1:0] WR   = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  localparam logic [ADDR_WIDTH-3:0] WORD_LIMIT = (ADDR_WIDTH-2)'(MEM_WORDS);

  logic [1:0]            state;
  logic                  lat_write;
  logic [2:0]            lat_funct3;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [31:0]           lat_wdata;
  logic [31:0]           old_word;

  logic                  illegal;
  logic                  misaligned;
  logic                  out_of_range;
  logic [7:0]            byte_lane;
  logic [15:0]           half_lane;
  logic [31:0]           load_data;
  logic [31:0]           store_word;
  logic [ADDR_WIDTH-1:0] word_addr;

  assign illegal = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) ||
                   (req_write && req_funct3[2]);

`ifdef LSU_MISALIGN_TRAP_EN
  assign misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                      ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  assign out_of_range = (req_addr[ADDR_WIDTH-1:2] >= WORD_LIMIT);

  // Halfwords select on addr[1] only, so addr[0] is ignored when traps are off
  always_comb begin
    byte_lane = 8'h00;
    case (lat_addr[1:0])
      2'd0:    byte_lane = mem_rdata[7:0];
      2'd1:    byte_lane = mem_rdata[15:8];
      2'd2:    byte_lane = mem_rdata[23:16];
      default: byte_lane = mem_rdata[31:24];
    endcase
    half_lane = lat_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    load_data = 32'h0;
    case (lat_funct3)
      3'b000:  load_data = {{24{byte_lane[7]}}, byte_lane};
      3'b001:  load_data = {{16{half_lane[15]}}, half_lane};
      3'b010:  load_data = mem_rdata;
      3'b100:  load_data = {24'h0, byte_lane};
      3'b101:  load_data = {16'h0, half_lane};
      default: load_data = 32'h0;
    endcase
  end

  always_comb begin
    store_word = old_word;
    case (lat_funct3[1:0])
      2'b00: store_word[{lat_addr[1:0], 3'b000} +: 8] = lat_wdata[7:0];
      2'b01: begin
        if (lat_addr[1]) store_word[31:16] = lat_wdata[15:0];
        else             store_word[15:0]  = lat_wdata[15:0];
      end
      default: store_word = lat_wdata;
    endcase
  end

  assign word_addr  = {lat_addr[ADDR_WIDTH-1:2], 2'b00};
  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign mem_read   = (state == RD);
  assign mem_write  = (state == WR);
  assign mem_addr   = (state == RD || state == WR) ? 32'(word_addr) : 32'h0;
  assign mem_wdata  = (state == WR) ? store_word : 32'h0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      lat_write  <= 1'b0;
      lat_funct3 <= 3'b000;
      lat_addr   <= '0;
      lat_wdata  <= 32'h0;
      old_word   <= 32'h0;
      resp_rdata <= 32'h0;
      resp_fault <= 1'b0;
      resp_cause <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            lat_write  <= req_write;
            lat_funct3 <= req_funct3;
            lat_addr   <= req_addr;
            lat_wdata  <= req_wdata;
            if (illegal || misaligned || out_of_range) begin
              resp_rdata <= 32'h0;
              resp_fault <= 1'b1;
              resp_cause <= illegal ? 2'b11 : (misaligned ? 2'b01 : 2'b10);
              state      <= RESP;
            end else if (req_write && req_funct3[1:0] == 2'b10) begin
              state <= WR;
            end else begin
              state <= RD;
            end
          end
        end
        RD: begin
          if (lat_write) begin
            old_word <= mem_rdata;
            state    <= WR;
          end else begin
            resp_rdata <= load_data;
            resp_fault <= 1'b0;
            resp_cause <= 2'b00;
            state      <= RESP;
          end
        end
        WR: begin
          resp_rdata <= 32'h0;
          resp_fault <= 1'b0;
          resp_cause <= 2'b00;
          state      <= RESP;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
